ahb_icache: RTL and testbench
=============================

Name: ahb_icache

Overview:
- Direct-mapped, read-only cache between a word-fetch requester (e.g. the core's fetch stage) and an AHB-Lite master port.
- Hits return a word one cycle after the request.
- Misses refill the whole 8-word line from the AHB bus, then return the requested word.
- No write path; the AHB port only reads.

Parameters:
- WORD_WIDTH, 32, data word width.
- BLOCK_WIDTH, 256, line width in bits (WORD_WIDTH*BLOCK_WIDTH_WORDS).
- BLOCK_WIDTH_WORDS, 8, words per line.
- BLOCK_SIZE, 32, number of lines.
- LOG2_BLOCK_WIDTH_WORDS, 3, word-offset bits.
- LOG2_BLOCK_SIZE, 5, index bits.
- TAG_WIDTH, 22, tag bits (ADDR_WIDTH-LOG2_BLOCK_SIZE-LOG2_BLOCK_WIDTH_WORDS-2).
- ADDR_WIDTH, 32, address width.
- HBURST_WIDTH, 1, HBURST width.
- HPROT_WIDTH, 1, HPROT width.
- HMASTER_WIDTH, 1, HMASTER width.

Ports:
- clk in 1: single clock; the AHB side also runs on clk; no separate HCLK/HRESETn.
- rst in 1: asynchronous, active-high reset.
- req in 1: fetch request; held high with addr stable until valid.
- addr in ADDR_WIDTH: byte address, word aligned.
- valid out 1: data valid, one-cycle pulse per served request.
- data out WORD_WIDTH: returned word.
- HADDR out ADDR_WIDTH: AHB address.
- HBURST out HBURST_WIDTH: constant 0 (SINGLE).
- HMASTLOCK out 1: constant 0.
- HPROT out HPROT_WIDTH: constant 0 (opcode fetch).
- HSIZE out 3: constant 3'b010 (word).
- HNONSEC out 1: constant 0.
- HEXCL out 1: constant 0.
- HMASTER out HMASTER_WIDTH: constant 0.
- HTRANS out 2: 2'b00 IDLE or 2'b10 NONSEQ.
- HWDATA out WORD_WIDTH: constant 0.
- HWSTRB out WORD_WIDTH/8: constant 0.
- HWRITE out 1: constant 0.
- HRDATA in WORD_WIDTH: read data.
- HREADY in 1: transfer ready.
- HRESP in 1: 1 = error.
- HEXOKAY in 1: ignored.

Behaviour:
- Address split:
  - addr[1:0] is the byte offset and is ignored.
  - addr[4:2] is the word offset.
  - addr[9:5] is the index.
  - addr[31:10] is the tag.
- Storage per line: valid bit, tag, 8 data words.
- Reset (async, rst=1):
  - All line valid bits cleared; FSM in IDLE.
  - valid=0, data=0, HTRANS=IDLE, HADDR=0.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE, req=1 and hit (line valid and tag equal):
  - Next clock edge registers valid=1 and data=word.
  - Latency is 1 cycle.
  - If req stays high, a lookup happens every cycle, so back-to-back hits give 1 word per cycle.
- IDLE, req=1 and miss:
  - Latch the line base address {tag,index,5'b0}; go to REFILL. valid stays 0.
- REFILL: 8 SINGLE NONSEQ word reads at base+0,4,...,28, pipelined per AHB-Lite.
  - Address phase k is driven with HTRANS=NONSEQ and HADDR=base+4k.
  - The address advances only on cycles with HREADY=1.
  - Data for beat k is captured from HRDATA in the first HREADY=1 cycle after its address phase was accepted.
  - After the 8th address is accepted, HTRANS=IDLE.
  - When the 8th data beat is captured: write the line, set tag and valid bit, go to RESPOND.
- RESPOND: valid=1 for one cycle, data = requested word from the new line; then IDLE.
- HRESP=1 during any data phase:
  - Abort the refill; HTRANS=IDLE; the line valid bit is not set; return to IDLE; valid stays 0.
  - If req is still held, the request re-executes as a miss.
- req=0 in IDLE: no activity, valid=0.
  - data holds its last value and is meaningful only when valid=1.
- req deasserted mid-refill: the refill completes and the line is installed; the RESPOND pulse is still issued.
- Conflict miss: a new tag overwrites the line at the same index; no write-back, as the cache is read-only.
- rst asserted mid-refill:
  - Immediate abort; all lines invalid; HTRANS=IDLE.
  - No partial line retained.
- HTRANS is never 2'b01 or 2'b11.
- All AHB outputs are registered.

Test Plan:
- Reset: assert rst → valid=0, HTRANS=00, HWRITE=0, HSIZE=3'b010, HADDR=0.
- Cold miss: req=1, addr=0x0000_0014; memory returns word = address → 8 NONSEQ reads at 0x00,0x04..0x1C; then valid=1, data=0x0000_0014 for 1 cycle.
- Hit after refill: addr=0x0000_0008 → valid=1 one cycle later, data=0x0000_0008, HTRANS stays 00.
- Wait states: HREADY=0 for 2 cycles on beat 3 → HADDR holds 0x0C, data still correct, total refill latency +2.
- Conflict: addr=0x0000_0400 (same index 0, tag 1) → full refill at 0x400..0x41C; then addr=0x0000_0000 misses again.
- Error: HRESP=1 on beat 5 → refill aborted, no valid pulse, next access to same line misses again.

Source files
------------

// File: rtl/ahb_icache.sv
// ahb_icache: direct-mapped, read-only instruction cache in front of an
// AHB-Lite master port.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | look up req/addr every cycle; hit -> valid next cycle
// REFILL| 8 pipelined SINGLE NONSEQ reads fill the missing line
// RESPOND| line installed, valid/data presented for one cycle
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req, addr         : fetch request and word-aligned byte address
//   valid, data       : one-cycle response pulse and returned word
//   H* outputs        : AHB-Lite master address/control (registered)
//   HRDATA/HREADY/HRESP/HEXOKAY : AHB-Lite slave response
module ahb_icache #(
    parameter int WORD_WIDTH             = 32,
    parameter int BLOCK_WIDTH            = 256,
    parameter int BLOCK_WIDTH_WORDS      = 8,
    parameter int BLOCK_SIZE             = 32,
    parameter int LOG2_BLOCK_WIDTH_WORDS = 3,
    parameter int LOG2_BLOCK_SIZE        = 5,
    parameter int TAG_WIDTH              = 22,
    parameter int ADDR_WIDTH             = 32,
    parameter int HBURST_WIDTH           = 1,
    parameter int HPROT_WIDTH            = 1,
    parameter int HMASTER_WIDTH          = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [ADDR_WIDTH-1:0]     addr,
    output logic                      valid,
    output logic [WORD_WIDTH-1:0]     data,
    output logic [ADDR_WIDTH-1:0]     HADDR,
    output logic [HBURST_WIDTH-1:0]   HBURST,
    output logic                      HMASTLOCK,
    output logic [HPROT_WIDTH-1:0]    HPROT,
    output logic [2:0]                HSIZE,
    output logic                      HNONSEC,
    output logic                      HEXCL,
    output logic [HMASTER_WIDTH-1:0]  HMASTER,
    output logic [1:0]                HTRANS,
    output logic [WORD_WIDTH-1:0]     HWDATA,
    output logic [WORD_WIDTH/8-1:0]   HWSTRB,
    output logic                      HWRITE,
    input  logic [WORD_WIDTH-1:0]     HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP,
    input  logic                      HEXOKAY
);

    localparam int OW = LOG2_BLOCK_WIDTH_WORDS;
    localparam int IW = LOG2_BLOCK_SIZE;
    localparam logic [OW-1:0] LAST_WORD = OW'(BLOCK_WIDTH_WORDS - 1);
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND} state_t;

    state_t state, state_nxt;

    logic [BLOCK_SIZE-1:0]  line_valid, line_valid_nxt;
    logic [TAG_WIDTH-1:0]   tag_mem  [BLOCK_SIZE];
    logic [BLOCK_WIDTH-1:0] line_mem [BLOCK_SIZE];

    logic [TAG_WIDTH-1:0] ref_tag, ref_tag_nxt;
    logic [IW-1:0]        ref_index, ref_index_nxt;
    logic [OW-1:0]        ref_off, ref_off_nxt;
    logic [OW-1:0]        a_cnt, a_cnt_nxt;
    logic [OW-1:0]        d_cnt, d_cnt_nxt;
    logic                 dphase, dphase_nxt;

    logic [1:0]             htrans_nxt;
    logic [ADDR_WIDTH-1:0]  haddr_nxt;
    logic                   valid_nxt;
    logic [WORD_WIDTH-1:0]  data_nxt;
    logic                   wr_en;
    logic                   tag_we;

    logic [TAG_WIDTH-1:0] in_tag;
    logic [IW-1:0]        in_index;
    logic [OW-1:0]        in_off;
    logic                 hit;

    assign in_tag   = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign in_index = addr[2+OW +: IW];
    assign in_off   = addr[2 +: OW];
    assign hit      = line_valid[in_index] && (tag_mem[in_index] == in_tag);

    assign HBURST    = '0;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = '0;
    assign HSIZE     = 3'b010;
    assign HNONSEC   = 1'b0;
    assign HEXCL     = 1'b0;
    assign HMASTER   = '0;
    assign HWDATA    = '0;
    assign HWSTRB    = '0;
    assign HWRITE    = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, HEXOKAY, addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            line_valid <= '0;
            ref_tag    <= '0;
            ref_index  <= '0;
            ref_off    <= '0;
            a_cnt      <= '0;
            d_cnt      <= '0;
            dphase     <= 1'b0;
            HTRANS     <= T_IDLE;
            HADDR      <= '0;
            valid      <= 1'b0;
            data       <= '0;
        end else begin
            state      <= state_nxt;
            line_valid <= line_valid_nxt;
            ref_tag    <= ref_tag_nxt;
            ref_index  <= ref_index_nxt;
            ref_off    <= ref_off_nxt;
            a_cnt      <= a_cnt_nxt;
            d_cnt      <= d_cnt_nxt;
            dphase     <= dphase_nxt;
            HTRANS     <= htrans_nxt;
            HADDR      <= haddr_nxt;
            valid      <= valid_nxt;
            data       <= data_nxt;
        end
    end

    // Line storage carries no reset; line_valid alone decides whether it is usable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_mem[ref_index][d_cnt*WORD_WIDTH +: WORD_WIDTH] <= HRDATA;
        end
        if (tag_we) begin
            tag_mem[ref_index] <= ref_tag;
        end
    end

    always_comb begin
        state_nxt      = state;
        line_valid_nxt = line_valid;
        ref_tag_nxt    = ref_tag;
        ref_index_nxt  = ref_index;
        ref_off_nxt    = ref_off;
        a_cnt_nxt      = a_cnt;
        d_cnt_nxt      = d_cnt;
        dphase_nxt     = dphase;
        htrans_nxt     = HTRANS;
        haddr_nxt      = HADDR;
        valid_nxt      = 1'b0;
        data_nxt       = data;
        wr_en          = 1'b0;
        tag_we         = 1'b0;

        case (state)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        valid_nxt = 1'b1;
                        data_nxt  = line_mem[in_index][in_off*WORD_WIDTH +: WORD_WIDTH];
                    end else begin
                        // The line is overwritten in place, so drop its valid bit now;
                        // an aborted refill then leaves it invalid.
                        line_valid_nxt[in_index] = 1'b0;
                        ref_tag_nxt   = in_tag;
                        ref_index_nxt = in_index;
                        ref_off_nxt   = in_off;
                        a_cnt_nxt     = '0;
                        d_cnt_nxt     = '0;
                        dphase_nxt    = 1'b0;
                        htrans_nxt    = T_NONSEQ;
                        haddr_nxt     = {in_tag, in_index, {OW{1'b0}}, 2'b00};
                        state_nxt     = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                if (dphase && HRESP) begin
                    // Error on the first response cycle: cancel the pending address phase.
                    htrans_nxt = T_IDLE;
                    dphase_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end else if (HREADY) begin
                    if (dphase) begin
                        wr_en     = 1'b1;
                        d_cnt_nxt = d_cnt + 1'b1;
                        if (d_cnt == LAST_WORD) begin
                            line_valid_nxt[ref_index] = 1'b1;
                            tag_we     = 1'b1;
                            valid_nxt  = 1'b1;
                            // The last word is only on HRDATA this cycle, not in the array yet.
                            data_nxt   = (ref_off == LAST_WORD) ? HRDATA
                                       : line_mem[ref_index][ref_off*WORD_WIDTH +: WORD_WIDTH];
                            dphase_nxt = 1'b0;
                            state_nxt  = S_RESPOND;
                        end
                    end
                    if (HTRANS == T_NONSEQ) begin
                        dphase_nxt = 1'b1;
                        if (a_cnt == LAST_WORD) begin
                            htrans_nxt = T_IDLE;
                        end else begin
                            a_cnt_nxt = a_cnt + 1'b1;
                            haddr_nxt = {ref_tag, ref_index, a_cnt + 1'b1, 2'b00};
                        end
                    end
                end
            end

            S_RESPOND: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt  = S_IDLE;
                htrans_nxt = T_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_icache.sv
module tb_ahb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic [31:0] HADDR;
    logic [0:0]  HBURST;
    logic        HMASTLOCK;
    logic [0:0]  HPROT;
    logic [2:0]  HSIZE;
    logic        HNONSEC;
    logic        HEXCL;
    logic [0:0]  HMASTER;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [3:0]  HWSTRB;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        HEXOKAY;

    ahb_icache dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .valid(valid), .data(data),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HNONSEC(HNONSEC), .HEXCL(HEXCL), .HMASTER(HMASTER),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HEXOKAY(HEXOKAY)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Backing memory: every word holds its own address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    // Reference model: which line currently lives at each index.
    bit          mvalid [32];
    logic [21:0] mtag   [32];

    // AHB slave model with wait-state and error injection.
    logic        dp_v = 1'b0;
    logic [31:0] dp_a = '0;
    int          err_ph = 0;
    logic        err_armed = 1'b0;
    logic        err_fired = 1'b0;
    logic [31:0] err_addr = '1;
    logic [31:0] stall_addr = '1;
    int          stall_left = 0;
    logic [31:0] bus_q[$];
    logic [31:0] stall_q[$];
    int          bad_htrans = 0;
    int          vcnt = 0;

    initial begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dp_v   = 1'b0;
                err_ph = 0;
                HREADY = 1'b1;
                HRESP  = 1'b0;
                continue;
            end
            HREADY = 1'b1;
            HRESP  = 1'b0;
            if (dp_v) begin
                if (err_ph == 1) begin
                    HRESP  = 1'b1;
                    err_ph = 0;
                end else if (err_armed && dp_a == err_addr) begin
                    err_armed = 1'b0;
                    err_fired = 1'b1;
                    HRESP  = 1'b1;
                    HREADY = 1'b0;
                    err_ph = 1;
                end else if (dp_a == stall_addr && stall_left > 0) begin
                    HREADY = 1'b0;
                    stall_left--;
                    stall_q.push_back(HADDR);
                end else begin
                    HRDATA = word(dp_a);
                end
            end
            if (HREADY) begin
                dp_v = (HTRANS == 2'b10);
                if (dp_v) begin
                    dp_a = HADDR;
                    bus_q.push_back(HADDR);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (HTRANS == 2'b01 || HTRANS == 2'b11) bad_htrans++;
        if (valid) vcnt++;
    end

    // Issue one request (caller is at posedge+1) and hold it until valid.
    task automatic do_req(input logic [31:0] a, output int lat, output logic [31:0] d);
        bus_q.delete();
        req  = 1'b1;
        addr = a;
        lat  = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (valid) break;
        end
        if (!valid) check("req_timeout", 32'd0, 32'd1);
        d   = data;
        req = 1'b0;
        @(posedge clk); #1;
        check("pulse_width", {31'd0, valid}, 32'd0);
    endtask

    task automatic access(input logic [31:0] a, input int st_beat, input int st_n);
        int          idx;
        logic [21:0] tg;
        logic [31:0] base;
        bit          hit;
        int          lat;
        logic [31:0] d;
        idx  = int'(a[9:5]);
        tg   = a[31:10];
        base = {a[31:5], 5'b0};
        hit  = mvalid[idx] && (mtag[idx] == tg);
        stall_q.delete();
        if (st_beat >= 0 && !hit) begin
            stall_addr = base + 32'(4 * st_beat);
            stall_left = st_n;
        end else begin
            stall_addr = '1;
            stall_left = 0;
        end
        do_req(a, lat, d);
        check("data", d, word(a));
        check("latency", lat, hit ? 32'd1 : 32'(10 + ((st_beat >= 0) ? st_n : 0)));
        check("nbeats", bus_q.size(), hit ? 32'd0 : 32'd8);
        if (!hit) begin
            for (int i = 0; i < 8 && i < bus_q.size(); i++)
                check("beat_addr", bus_q[i], base + 32'(4 * i));
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
        end
        stall_addr = '1;
        stall_left = 0;
    endtask

    initial begin
        logic [31:0] lst [4];
        int v0;
        rst = 1'b1; req = 1'b0; addr = '0; HEXOKAY = 1'b0;
        for (int i = 0; i < 32; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end

        repeat (2) @(posedge clk); #1;
        check("rst_valid",  {31'd0, valid}, 32'd0);
        check("rst_htrans", {30'd0, HTRANS}, 32'd0);
        check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        check("rst_hsize",  {29'd0, HSIZE}, 32'd2);
        check("rst_haddr",  HADDR, 32'd0);
        check("rst_data",   data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss, then hit in the same line.
        access(32'h0000_0014, -1, 0);
        access(32'h0000_0008, -1, 0);

        // Back-to-back hits, one word per cycle.
        lst[0] = 32'h00; lst[1] = 32'h04; lst[2] = 32'h1C; lst[3] = 32'h10;
        bus_q.delete();
        req = 1'b1; addr = lst[0];
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("b2b_valid", {31'd0, valid}, 32'd1);
            check("b2b_data", data, lst[k]);
            if (k < 3) addr = lst[k+1]; else req = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b_end", {31'd0, valid}, 32'd0);
        check("b2b_nobus", bus_q.size(), 32'd0);

        // Two wait states on beat 2's data phase; address of beat 3 must hold.
        access(32'h0000_002C, 2, 2);
        check("stall_cnt", stall_q.size(), 32'd2);
        for (int i = 0; i < stall_q.size(); i++) check("stall_haddr", stall_q[i], 32'h2C);

        // Conflict on index 0.
        access(32'h0000_0400, -1, 0);
        access(32'h0000_0000, -1, 0);

        // Error response on beat 5 of a refill.
        err_addr = 32'h54; err_armed = 1'b1; err_fired = 1'b0;
        v0 = vcnt;
        req = 1'b1; addr = 32'h44;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (err_fired) break;
        end
        check("err_seen", {31'd0, err_fired}, 32'd1);
        check("err_htrans", {30'd0, HTRANS}, 32'd0);
        req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("err_no_valid", vcnt - v0, 32'd0);
        access(32'h0000_0044, -1, 0);

        // Request dropped mid-refill still completes and responds.
        req = 1'b1; addr = 32'h68;
        repeat (3) begin @(posedge clk); #1; end
        req = 1'b0; addr = 32'hDEAD_BEE0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid) break;
        end
        check("drop_valid", {31'd0, valid}, 32'd1);
        check("drop_data", data, 32'h68);
        mvalid[3] = 1'b1; mtag[3] = '0;
        @(posedge clk); #1;
        access(32'h0000_006C, -1, 0);

        // Reset in the middle of a refill invalidates everything.
        req = 1'b1; addr = 32'h80;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrst_htrans", {30'd0, HTRANS}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
        @(posedge clk); #1;
        access(32'h0000_0008, -1, 0);
        access(32'h0000_0084, -1, 0);

        // Randomized traffic over a few tags and indexes.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            int sb;
            int sn;
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5)
               | (32'($urandom_range(0, 7)) << 2);
            sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            sn = int'($urandom_range(1, 3));
            access(a, sb, sn);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        check("htrans_legal", bad_htrans, 32'd0);
        check("hwrite_const", {31'd0, HWRITE}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
